ctr_seq_ctrl: RTL
=================

# ctr_seq_ctrl

Command-driven controller that drives the control side of the design's 8-bit loadable up/down counter: parallel load, count enable, direction and output enable. It takes one command (start value, target value, direction), loads the counter, enables it for exactly the number of cycles needed to reach the target, reads the count bus back, and reports completion. It sits between command logic and the counter instance, and is the initiator for the counter's control pins.

## Interface
Parameters:
- WIDTH, 8, width of the count, load and readback buses.

Ports:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller can accept a command.
- cmd_start  in  WIDTH  value loaded into the counter.
- cmd_target  in  WIDTH  value at which counting stops.
- cmd_up  in  1  direction: 1 = up, 0 = down.
- cnt_load  out  1  counter synchronous load strobe.
- cnt_d  out  WIDTH  counter parallel load data.
- cnt_en  out  1  counter count enable.
- cnt_up  out  1  counter direction.
- cnt_oe  out  1  counter output enable.
- cnt_y  in  WIDTH  counter readback bus; valid only while cnt_oe=1.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- steps  out  WIDTH  enable cycles issued for the last command.
- err  out  1  sticky readback mismatch (see Configuration).

## Operation
- States: IDLE, LOAD, RUN, CHECK, DONE. All control outputs are Moore-decoded from the state and registered fields.
- IDLE: cmd_ready=1 and all cnt_* strobes are 0. cmd_valid=1 is the accept. On accept, start, target and direction are captured, exp<=cmd_start, steps<=0, err<=0, and the FSM goes to LOAD. Command inputs are ignored outside the accept cycle.
- LOAD (1 cycle): cnt_load=1, cnt_d=start, cnt_oe=1.
  - If start==target, go to CHECK.
  - Otherwise go to RUN.
- RUN: cnt_en=1, cnt_up=dir, cnt_oe=1. Each cycle:
  - exp<=exp±1 and steps<=steps+1.
  - When the new exp equals target, go to CHECK.
- CHECK (1 cycle): cnt_oe=1, cnt_en=0, cnt_load=0. Readback compare is done here (macro-dependent). Then go to DONE.
- DONE (1 cycle): done=1, then go to IDLE.
- busy=1 in LOAD, RUN, CHECK and DONE. cnt_up holds the captured direction from LOAD through DONE, and is 0 in IDLE.
- Arithmetic: exp and steps wrap modulo 2^WIDTH. steps = (target−start) mod 2^WIDTH when counting up, and (start−target) mod 2^WIDTH when counting down. Wrap-around through 255→0 or 0→255 is legal, and the maximum step count is 255.
- steps and err hold their final values in IDLE until the next accept.

## Timing
- Accept at cycle T (IDLE, cmd_valid=1). LOAD is at T+1, RUN spans T+2…T+1+N, CHECK is at T+2+N, DONE (done=1) is at T+3+N, and cmd_ready=1 again at T+4+N.
- For N=0: LOAD at T+1, CHECK at T+2, done at T+3.
- With the counter's load taking effect on the LOAD edge, the counter value equals exp in every RUN cycle and equals target in CHECK.
- Reset (rst=1 sampled at an edge) applies in any state, including mid-RUN:
  - state=IDLE, exp=0, steps=0, err=0.
  - cnt_load=cnt_en=cnt_up=cnt_oe=0, cnt_d=0, done=0, busy=0.
  - cmd_ready=1 from the first edge after rst is sampled.
  - A command offered while rst=1 is not accepted.
- Back-to-back: a new command can be accepted in the IDLE cycle directly after DONE.

## Configuration
- Macro: CTR_SEQ_READBACK_CHECK_EN.
- Defined:
  - In every RUN cycle, if cnt_y != exp, err<=1.
  - In CHECK, if cnt_y != target, err<=1.
  - err is sticky until the next accept or reset.
- Not defined: no compare logic is built, err is tied to 0, and the FSM and timing are unchanged.

## Test plan
- Up, no wrap: start=5, target=9, up=1, with the counter model attached. Required: cnt_en high for 4 cycles, done at T+7, steps=4, model=9, err=0.
- Down with wrap: start=2, target=254, up=0. Required: 4 enable cycles, readback sequence 2,1,0,255 in RUN, then 254 in CHECK; steps=4.
- Zero-length: start=target=0x3C. Required: no cnt_en cycle, done at T+3, steps=0, model=0x3C.
- Reset mid-RUN: start=0, target=200, up=1, rst asserted at T+10. Required: next edge has all cnt_* outputs 0, busy=0, cmd_ready=1, and no done pulse.
- Mismatch (macro defined): force cnt_y=0xFF during RUN of start=0, target=3. Required: err=1 latched through done and IDLE, and cleared on the next accept.
- Back-to-back: accept a second command in the IDLE cycle after done. Required: LOAD on the following cycle with the new cnt_d, and no lost or extra cycle.

Source files
------------

// File: rtl/ctr_seq_ctrl_if.sv
// Command and counter-control interfaces for ctr_seq_ctrl.
// Command side: master offers start/target/direction, slave answers with ready.
// Counter side: master drives load/enable/direction/output-enable, slave returns the count.

interface ctr_seq_cmd_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_start;
  logic [WIDTH-1:0] cmd_target;
  logic             cmd_up;

  modport master (
    output cmd_valid, cmd_start, cmd_target, cmd_up,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_target, cmd_up,
    output cmd_ready
  );
endinterface

interface ctr_seq_cnt_if #(
  parameter int unsigned WIDTH = 8
);
  logic             cnt_load;
  logic [WIDTH-1:0] cnt_d;
  logic             cnt_en;
  logic             cnt_up;
  logic             cnt_oe;
  logic [WIDTH-1:0] cnt_y;

  modport master (
    output cnt_load, cnt_d, cnt_en, cnt_up, cnt_oe,
    input  cnt_y
  );

  modport slave (
    input  cnt_load, cnt_d, cnt_en, cnt_up, cnt_oe,
    output cnt_y
  );
endinterface

// File: rtl/ctr_seq_ctrl.sv
// ctr_seq_ctrl: loads an up/down counter with a start value, enables it for
// exactly the number of cycles needed to reach the target, then reports done.
// Optional readback checking is built when CTR_SEQ_READBACK_CHECK_EN is defined;
// otherwise err is held at 0 and the sequencing is identical.
// All outputs are registered; they are decoded from the next state so they
// line up with the state register cycle for cycle.

module ctr_seq_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  ctr_seq_cmd_if.slave     cmd,
  ctr_seq_cnt_if.master    cnt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] steps,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    RUN   = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] start_q, start_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] exp_nxt;
  logic [WIDTH-1:0] steps_d;
  logic             err_d;

  logic             ready_d;
  logic             load_d;
  logic [WIDTH-1:0] data_d;
  logic             en_d;
  logic             up_d;
  logic             oe_d;
  logic             busy_d;
  logic             done_d;

`ifndef CTR_SEQ_READBACK_CHECK_EN
  // Readback bus is not observed when checking is compiled out.
  logic unused_cnt_y;
  assign unused_cnt_y = ^cnt.cnt_y;
`endif

  // Next-state, datapath updates and output decode of the next state.
  always_comb begin
    state_d  = state;
    start_d  = start_q;
    target_d = target_q;
    dir_d    = dir_q;
    exp_d    = exp_q;
    steps_d  = steps;
    err_d    = err;
    exp_nxt  = dir_q ? (exp_q + WIDTH'(1)) : (exp_q - WIDTH'(1));

    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          start_d  = cmd.cmd_start;
          target_d = cmd.cmd_target;
          dir_d    = cmd.cmd_up;
          exp_d    = cmd.cmd_start;
          steps_d  = '0;
          err_d    = 1'b0;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        state_d = (start_q == target_q) ? CHECK : RUN;
      end
      RUN: begin
        exp_d   = exp_nxt;
        steps_d = steps + WIDTH'(1);
`ifdef CTR_SEQ_READBACK_CHECK_EN
        if (cnt.cnt_y != exp_q) err_d = 1'b1;
`endif
        if (exp_nxt == target_q) state_d = CHECK;
      end
      CHECK: begin
`ifdef CTR_SEQ_READBACK_CHECK_EN
        if (cnt.cnt_y != target_q) err_d = 1'b1;
`endif
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d = (state_d == IDLE);
    load_d  = (state_d == LOAD);
    data_d  = (state_d == LOAD) ? start_d : '0;
    en_d    = (state_d == RUN);
    up_d    = (state_d != IDLE) ? dir_d : 1'b0;
    oe_d    = (state_d == LOAD) || (state_d == RUN) || (state_d == CHECK);
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      start_q       <= '0;
      target_q      <= '0;
      dir_q         <= 1'b0;
      exp_q         <= '0;
      steps         <= '0;
      err           <= 1'b0;
      cmd.cmd_ready <= 1'b1;
      cnt.cnt_load  <= 1'b0;
      cnt.cnt_d     <= '0;
      cnt.cnt_en    <= 1'b0;
      cnt.cnt_up    <= 1'b0;
      cnt.cnt_oe    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_d;
      start_q       <= start_d;
      target_q      <= target_d;
      dir_q         <= dir_d;
      exp_q         <= exp_d;
      steps         <= steps_d;
      err           <= err_d;
      cmd.cmd_ready <= ready_d;
      cnt.cnt_load  <= load_d;
      cnt.cnt_d     <= data_d;
      cnt.cnt_en    <= en_d;
      cnt.cnt_up    <= up_d;
      cnt.cnt_oe    <= oe_d;
      busy          <= busy_d;
      done          <= done_d;
    end
  end

endmodule
